ccff_chain_loader: RTL and testbench

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_chain_loader_if.sv | 16 +
 rtl/ccff_chain_loader.sv | 59 +++++
 tb/tb_ccff_chain_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ccff_chain_loader_if.sv
// ccff_chain_loader_if: word handshake and chain-drive signals of the ccff chain loader
interface ccff_chain_loader_if #(parameter int WORD_W = 8);
    logic              start;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_clk_en;
    logic              busy;
    logic              done;
    logic [15:0]       bits_loaded;
    modport master (output start, word_in, word_valid,
                    input word_ready, ccff_head, ccff_clk_en, busy, done, bits_loaded);
    modport slave (input start, word_in, word_valid,
                   output word_ready, ccff_head, ccff_clk_en, busy, done, bits_loaded);
endinterface

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises bitstream words MSB-first into a gated ccff configuration chain
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input logic               prog_clk,
    input logic               prog_reset,
    ccff_chain_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
    state_t            state, nxt;
    logic [WORD_W-1:0] sr;
    logic [5:0]        idx;
    logic [15:0]       bits_loaded;
    logic              last_word, last_chain, ready, hs;
    always_comb begin
        last_word  = idx == 6'(WORD_W - 1);
        last_chain = bits_loaded == 16'(CHAIN_LEN - 1);
        ready      = state == LOAD || (state == SHIFT && last_word && !last_chain);
        hs         = ready && bus.word_valid;
        nxt        = state;
        if (state == IDLE)
            nxt = bus.start ? LOAD : IDLE;
        else if (state == LOAD)
            nxt = hs ? SHIFT : LOAD;
        else if (state == SHIFT)
            nxt = last_chain ? DONE : (last_word && !hs) ? LOAD : SHIFT;
        else
            nxt = IDLE;
    end
    assign bus.word_ready  = ready;
    assign bus.ccff_clk_en = state == SHIFT;
    assign bus.ccff_head   = state == SHIFT && sr[WORD_W-1];
    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.bits_loaded = bits_loaded;
    // a word captured in the last-bit cycle replaces the register instead of shifting it
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            state       <= IDLE;
            sr          <= '0;
            idx         <= '0;
            bits_loaded <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.start)
                bits_loaded <= '0;
            if (state == SHIFT)
                bits_loaded <= bits_loaded + 16'd1;
            if (hs) begin
                sr  <= bus.word_in;
                idx <= '0;
            end else if (state == SHIFT) begin
                sr  <= sr << 1;
                idx <= idx + 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench; expected chain bits queued at word handshake, popped on each ccff_clk_en
module tb_ccff_chain_loader;
    localparam int C = 12;
    localparam int W = 8;

    logic clk = 0;
    logic rst = 1;
    always #5 clk = ~clk;

    ccff_chain_loader_if #(.WORD_W(W)) bus ();
    ccff_chain_loader #(.CHAIN_LEN(C), .WORD_W(W)) dut (.prog_clk(clk), .prog_reset(rst), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    bit q[$];
    bit exp_b;
    int en_cnt, idle_cnt, done_cnt, pushed;
    logic [C-1:0] chain = '0;
    logic [C-1:0] exp_chain;

    // reference model of the downstream chain: head enters bit 0, tail is bit C-1
    always @(posedge clk)
        if (bus.ccff_clk_en) chain <= {chain[C-2:0], bus.ccff_head};

    always @(negedge clk) begin
        n_checks++;
        if (bus.ccff_clk_en) begin
            en_cnt++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL extra_bit: ccff_clk_en=1 with no bit expected (head=%b)", bus.ccff_head);
            end else begin
                exp_b = q.pop_front();
                if (bus.ccff_head !== exp_b) begin
                    n_fail++;
                    $display("FAIL head_bit %0d: got %b want %b", en_cnt, bus.ccff_head, exp_b);
                end
            end
        end else begin
            if (bus.busy && !bus.done) idle_cnt++;
            if (bus.ccff_head !== 1'b0) begin
                n_fail++;
                $display("FAIL head_idle: got %b want 0", bus.ccff_head);
            end
        end
        if (bus.done) done_cnt++;
    end

    task automatic send_word(input logic [W-1:0] w, input int stall);
        int n = 0;
        bus.word_in = w;
        for (int t = 0; t < 200; t++) begin
            if (bus.word_ready) begin
                if (n == stall) begin
                    bus.word_valid = 1;
                    for (int i = W - 1; i >= 0; i--)
                        if (pushed < C) begin
                            q.push_back(w[i]);
                            exp_chain = {exp_chain[C-2:0], w[i]};
                            pushed++;
                        end
                    @(posedge clk); #1;
                    bus.word_valid = 0;
                    return;
                end
                n++;
            end
            @(posedge clk); #1;
        end
        n_checks++; n_fail++;
        $display("FAIL word_timeout: word_ready got 0 for 200 cycles, want 1");
    endtask

    task automatic test_reset();
        rst = 1; bus.start = 1; bus.word_valid = 1; bus.word_in = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.word_ready, bus.ccff_head, bus.ccff_clk_en, bus.busy, bus.done} !== 5'b0 || bus.bits_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/head/en/busy/done=%b bits=%0d want 00000 bits=0",
                     {bus.word_ready, bus.ccff_head, bus.ccff_clk_en, bus.busy, bus.done}, bus.bits_loaded);
        end
        bus.start = 0;
        @(posedge clk); #1;
        rst = 0;
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (bus.busy !== 1'b0 || bus.word_ready !== 1'b0 || en_cnt !== 0) begin
            n_fail++;
            $display("FAIL valid_in_idle: busy=%b rdy=%b en_cnt=%0d want 0 0 0", bus.busy, bus.word_ready, en_cnt);
        end
        bus.word_valid = 0;
    endtask

    task automatic test_load(input logic [W-1:0] w1, input logic [W-1:0] w2, input int stall,
                             input bit start_mid, input bit start_done, input int exp_idle);
        bit seen = 0;
        q.delete(); en_cnt = 0; idle_cnt = 0; done_cnt = 0; pushed = 0; exp_chain = '0;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        n_checks++;
        if (bus.word_ready !== 1'b1 || bus.bits_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL start_latency: rdy=%b bits=%0d want 1 0", bus.word_ready, bus.bits_loaded);
        end
        send_word(w1, 0);
        if (start_mid) begin
            bus.start = 1;
            @(posedge clk); #1;
            bus.start = 0;
        end
        send_word(w2, stall);
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            seen = bus.done;
        end
        if (seen && start_done) begin
            bus.start = 1;
            @(posedge clk); #1;
            bus.start = 0;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout: done got 0 for 100 cycles, want 1");
        end
        repeat (3) @(posedge clk); #1;
        n_checks++;
        if (done_cnt !== 1 || en_cnt !== C || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_counts: done=%0d en=%0d busy=%b want 1 %0d 0", done_cnt, en_cnt, bus.busy, C);
        end
        n_checks++;
        if (bus.bits_loaded !== 16'(C)) begin
            n_fail++;
            $display("FAIL bits_loaded: got %0d want %0d", bus.bits_loaded, C);
        end
        n_checks++;
        if (q.size() !== 0 || idle_cnt !== exp_idle) begin
            n_fail++;
            $display("FAIL gaps: left=%0d idle=%0d want 0 %0d", q.size(), idle_cnt, exp_idle);
        end
        n_checks++;
        if (chain !== exp_chain) begin
            n_fail++;
            $display("FAIL chain: got %h want %h", chain, exp_chain);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int en_at;
        q.delete(); en_cnt = 0; pushed = 0; exp_chain = '0;
        bus.start = 1;
        @(posedge clk); #1;
        bus.start = 0;
        send_word(8'hA5, 0);
        for (int t = 0; t < 50 && k < 5; t++) begin
            @(negedge clk);
            if (bus.ccff_clk_en) k++;
        end
        rst = 1;
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.ccff_clk_en !== 1'b0 || bus.bits_loaded !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid: busy=%b en=%b bits=%0d want 0 0 0", bus.busy, bus.ccff_clk_en, bus.bits_loaded);
        end
        @(posedge clk); #1;
        rst = 0;
        en_at = en_cnt;
        q.delete();
        repeat (4) @(posedge clk); #1;
        n_checks++;
        if (en_at !== 5 || en_cnt !== 5 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort: en at reset=%0d after=%0d busy=%b want 5 5 0", en_at, en_cnt, bus.busy);
        end
        test_load(8'hF0, 8'h3C, 0, 0, 0, 1);
    endtask

    initial begin
        bus.start = 0; bus.word_valid = 0; bus.word_in = '0;
        en_cnt = 0; idle_cnt = 0; done_cnt = 0; pushed = 0; exp_chain = '0;
        test_reset();
        test_load(8'hA5, 8'h3C, 0, 0, 0, 1);
        test_load(8'hF0, 8'h3C, 0, 0, 0, 1);
        test_load(8'h96, 8'h6B, 3, 0, 0, 4);
        test_load(8'h5A, 8'hC3, 0, 1, 1, 1);
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
